// File: rtl/bcd_dec_stream_if.sv
// Stream bundle for bcd_dec_stream: BCD digit input channel and one-hot output channel.
// master = digit source / one-hot consumer side, slave = decoder side.
interface bcd_dec_stream_if;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_bcd;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [9:0] out_y;
   logic       out_err;
   logic       out_last;

   modport master (
      output in_valid, in_bcd, in_last, out_ready,
      input  in_ready, out_valid, out_y, out_err, out_last
   );

   modport slave (
      input  in_valid, in_bcd, in_last, out_ready,
      output in_ready, out_valid, out_y, out_err, out_last
   );
endinterface

// File: rtl/bcd_dec_stream.sv
// Streaming BCD digit to one-hot decimal decoder with a 2-entry output FIFO,
// saturating error count and frame-length reporting. Option: BCD_DEC_STRICT_EN.
module bcd_dec_stream #(
   parameter int CNT_W = 8,
   parameter int FRM_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   bcd_dec_stream_if.slave  bus,
   output logic [CNT_W-1:0] err_cnt,
   output logic [FRM_W-1:0] frame_len,
   output logic             frame_done
);

`ifdef BCD_DEC_STRICT_EN
   localparam logic STRICT = 1'b1;
`else
   localparam logic STRICT = 1'b0;
`endif

   localparam logic [CNT_W-1:0] ERR_MAX = '1;
   localparam logic [FRM_W-1:0] FRM_MAX = '1;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } fill_t;

   fill_t            fill_reg;
   logic             rd_ptr_reg;
   logic             wr_ptr_reg;
   logic [CNT_W-1:0] err_cnt_reg;
   logic [FRM_W-1:0] frame_cnt_reg;
   logic [FRM_W-1:0] frame_len_reg;
   logic             frame_done_reg;

   logic             invalid;
   logic             accept;
   logic             pop;
   logic             push;
   logic             out_valid;
   logic [9:0]       dec_y;
   logic [11:0]      entry_q [2];
   logic [11:0]      head;
   logic [FRM_W-1:0] frame_cnt_inc;

   assign invalid = (bus.in_bcd > 4'd9);
   assign dec_y   = invalid ? 10'd0 : (10'd1 << bus.in_bcd);

   // in_ready depends only on the registered fill level, never on out_ready.
   assign bus.in_ready = (fill_reg != FULL);
   assign out_valid    = (fill_reg != EMPTY);
   assign accept       = bus.in_valid & bus.in_ready;
   assign pop          = out_valid & bus.out_ready;
   assign push         = accept & ~(STRICT & invalid);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_reg   <= EMPTY;
         rd_ptr_reg <= 1'b0;
         wr_ptr_reg <= 1'b0;
      end else begin
         rd_ptr_reg <= rd_ptr_reg ^ pop;
         wr_ptr_reg <= wr_ptr_reg ^ push;
         case (fill_reg)
            EMPTY: if (push) fill_reg <= ONE;
            ONE: begin
               if (push && !pop)      fill_reg <= FULL;
               else if (pop && !push) fill_reg <= EMPTY;
            end
            FULL:    if (pop) fill_reg <= ONE;
            default: fill_reg <= EMPTY;
         endcase
      end
   end

   // Entry layout: {y[9:0], err, last}. The head slot is never the write slot
   // while occupied, so out_* stay frozen under backpressure.
   for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      logic [11:0] entry_reg;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            entry_reg <= '0;
         end else if (push && (wr_ptr_reg == 1'(gi))) begin
            entry_reg <= {dec_y, invalid, bus.in_last};
         end
      end

      assign entry_q[gi] = entry_reg;
   end

   assign head          = entry_q[rd_ptr_reg];
   assign bus.out_valid = out_valid;
   assign bus.out_y     = out_valid ? head[11:2] : 10'd0;
   assign bus.out_err   = out_valid & head[1] & ~STRICT;
   assign bus.out_last  = out_valid & head[0];

   assign frame_cnt_inc = (frame_cnt_reg == FRM_MAX) ? FRM_MAX : frame_cnt_reg + FRM_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_reg    <= '0;
         frame_cnt_reg  <= '0;
         frame_len_reg  <= '0;
         frame_done_reg <= 1'b0;
      end else begin
         frame_done_reg <= accept & bus.in_last;
         if (accept && invalid && (err_cnt_reg != ERR_MAX)) begin
            err_cnt_reg <= err_cnt_reg + CNT_W'(1);
         end
         // Invalid codes still count toward and may close the frame.
         if (accept) begin
            if (bus.in_last) begin
               frame_len_reg <= frame_cnt_inc;
               frame_cnt_reg <= '0;
            end else begin
               frame_cnt_reg <= frame_cnt_inc;
            end
         end
      end
   end

   assign err_cnt    = err_cnt_reg;
   assign frame_len  = frame_len_reg;
   assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_bcd_dec_stream.sv
// Scoreboard bench for bcd_dec_stream: a model process queues expected beats on each
// accept, an independent monitor pops and compares whenever the decoder presents a beat.
module tb_bcd_dec_stream;

   localparam int CNT_W   = 8;
   localparam int FRM_W   = 6;
   localparam int ERR_MAX = (1 << CNT_W) - 1;
   localparam int FRM_MAX = (1 << FRM_W) - 1;

`ifdef BCD_DEC_STRICT_EN
   localparam bit STRICT = 1'b1;
`else
   localparam bit STRICT = 1'b0;
`endif

   logic             clk;
   logic             rst;
   logic [CNT_W-1:0] err_cnt;
   logic [FRM_W-1:0] frame_len;
   logic             frame_done;

   bcd_dec_stream_if bus ();

   bcd_dec_stream #(
      .CNT_W (CNT_W),
      .FRM_W (FRM_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .err_cnt    (err_cnt),
      .frame_len  (frame_len),
      .frame_done (frame_done)
   );

   int checks = 0;
   int errors = 0;
   int beats  = 0;
   int mode   = 0;   // out_ready: 0 always high, 1 random, 2 held low

   // Reference model state
   logic [11:0] exp_q[$];
   int          exp_err   = 0;
   int          exp_len   = 0;
   int          frm_total = 0;
   bit          exp_done  = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
         endcase
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: decides what each accepted digit must produce, from the decoding rules.
   always @(negedge clk) begin
      logic       a;
      logic [3:0] b;
      logic       l;
      logic       inv;
      logic [9:0] y;
      a = !rst && bus.in_valid && bus.in_ready;
      b = bus.in_bcd;
      l = bus.in_last;
      #1;
      exp_done = a && l;
      if (a) begin
         inv = (b > 4'd9);
         if (inv && exp_err < ERR_MAX) exp_err++;
         frm_total++;
         if (l) begin
            exp_len   = (frm_total > FRM_MAX) ? FRM_MAX : frm_total;
            frm_total = 0;
         end
         if (!(STRICT && inv)) begin
            y = '0;
            for (int k = 0; k < 10; k++) if (int'(b) == k) y[k] = 1'b1;
            exp_q.push_back({y, inv, l});
         end
      end
   end

   // Monitor: compares every presented beat against the queue head.
   bit          prev_stall = 1'b0;
   logic [11:0] prev_beat;
   always @(negedge clk) begin
      logic [11:0] act;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         act = {bus.out_y, bus.out_err, bus.out_last};
         chk("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < 2));
         chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
         chk("err_cnt", 32'(err_cnt), 32'(exp_err));
         chk("frame_len", 32'(frame_len), 32'(exp_len));
         chk("frame_done", 32'(frame_done), 32'(exp_done));
         if (bus.out_valid && exp_q.size() != 0) begin
            chk("beat", 32'(act), 32'(exp_q[0]));
            if (prev_stall) chk("stall_hold", 32'(act), 32'(prev_beat));
            if (bus.out_ready) begin
               beats++;
               $display("beat %0d: y=%b err=%b last=%b", beats, bus.out_y, bus.out_err, bus.out_last);
               void'(exp_q.pop_front());
               prev_stall = 1'b0;
            end else begin
               prev_stall = 1'b1;
               prev_beat  = act;
            end
         end else begin
            if (!bus.out_valid) chk("idle_zero", 32'(act), 32'd0);
            prev_stall = 1'b0;
         end
      end
   end

   task automatic send(input logic [3:0] b, input logic l);
      int   n;
      logic a;
      n = 0;
      a = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_bcd   = b;
      bus.in_last  = l;
      while (!a && n < 200) begin
         @(negedge clk);
         a = bus.in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      bus.in_valid = 1'b0;
      if (!a) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got no accept expected accept for digit %0d", b);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      mode = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_bcd   = 4'd0;
      bus.in_last  = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_out_y", 32'(bus.out_y), 32'd0);
      chk("reset_err_cnt", 32'(err_cnt), 32'd0);
      chk("reset_frame_len", 32'(frame_len), 32'd0);
      chk("reset_frame_done", 32'(frame_done), 32'd0);

      // Digits 0..9 back to back, frame closed on 9.
      for (int d = 0; d < 10; d++) send(4'(d), d == 9);
      chk("frame_len_10", 32'(frame_len), 32'd10);
      drain();

      // Invalid codes.
      send(4'd12, 1'b0);
      send(4'd15, 1'b1);
      drain();
      chk("err_cnt_two", 32'(err_cnt), 32'd2);

      // Backpressure: two accepted, third held.
      mode = 2;
      send(4'd3, 1'b0);
      send(4'd7, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_bcd   = 4'd9;
      bus.in_last  = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      mode = 0;
      send(4'd9, 1'b1);
      drain();

      // Frame of 5 then a single-digit frame.
      for (int d = 0; d < 5; d++) send(4'(d + 1), d == 4);
      chk("frame5_done", 32'(frame_done), 32'd1);
      chk("frame5_len", 32'(frame_len), 32'd5);
      @(posedge clk);
      #1;
      chk("frame5_done_drop", 32'(frame_done), 32'd0);
      send(4'd8, 1'b1);
      chk("frame1_len", 32'(frame_len), 32'd1);

      // Error counter and frame counter saturation.
      mode = 1;
      for (int i = 0; i < 300; i++) send(4'($urandom_range(10, 15)), 1'b0);
      send(4'd0, 1'b1);
      drain();
      chk("err_cnt_sat", 32'(err_cnt), 32'(ERR_MAX));
      chk("frame_len_sat", 32'(frame_len), 32'(FRM_MAX));

      // Random traffic.
      mode = 1;
      for (int i = 0; i < 400; i++) begin
         send(4'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      drain();

      // Reset with two digits buffered mid-frame.
      mode = 2;
      send(4'd2, 1'b0);
      send(4'd6, 1'b0);
      #1 rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
      chk("midrst_frame_len", 32'(frame_len), 32'd0);
      chk("midrst_frame_done", 32'(frame_done), 32'd0);
      exp_q.delete();
      exp_err   = 0;
      exp_len   = 0;
      frm_total = 0;
      exp_done  = 1'b0;
      mode      = 0;
      @(posedge clk);
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      send(4'd5, 1'b1);
      chk("post_rst_frame_len", 32'(frame_len), 32'd1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
